mem_port_arbiter: RTL and testbench

Shares the single memory port of the rv32i core between the instruction-fetch requester and the load/store requester. Grants the requesters round-robin and sequences one memory transaction at a time with a req/ack handshake. Performs store byte-lane steering and load extraction / sign-extension per funct3. Reports misalignment, illegal funct3 and memory timeout as errors.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 77 +++++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and funct3 encodings for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } requester_e;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store steering, access legality, and load
// extraction with sign/zero extension.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic        is_fetch_i,
  input  logic        we_i,
  input  logic [2:0]  func_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        err_o,
  input  logic [2:0]  ld_func_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic        legal;
  logic        misal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    err_o   = 1'b0;
    legal   = 1'b1;
    misal   = 1'b0;
    if (is_fetch_i) begin
      err_o = (addr_lo_i != 2'b00);
    end else begin
      if (we_i) legal = func_i inside {F_B, F_H, F_W};
      else      legal = func_i inside {F_B, F_H, F_W, F_BU, F_HU};
      case (func_i[1:0])
        2'b01:   misal = addr_lo_i[0];
        2'b10:   misal = (addr_lo_i != 2'b00);
        default: misal = 1'b0;
      endcase
      err_o = !legal || misal;
      // Loads leave wdata/wstrb at zero so reads never strobe a lane.
      if (we_i && !err_o) begin
        case (func_i[1:0])
          2'b00: begin
            wstrb_o = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
          end
          2'b01: begin
            wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
          end
          default: begin
            wstrb_o = 4'b1111;
            wdata_o = wdata_i;
          end
        endcase
      end
    end
  end

  always_comb begin
    case (ld_addr_lo_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_func_i[1:0])
      2'b00:   ld_data_o = {{24{ld_byte[7] & ~ld_func_i[2]}}, ld_byte};
      2'b01:   ld_data_o = {{16{ld_half[15] & ~ld_func_i[2]}}, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store, one transaction at a time with a timeout on the memory ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  requester_e       last_q, last_d;
  requester_e       gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [2:0]       func_q, func_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             sel_fetch;
  logic [31:0]      sel_addr;
  logic [31:0]      al_wdata;
  logic [3:0]       al_wstrb;
  logic             al_err;
  logic [31:0]      ld_data;
  logic [CNT_W-1:0] cnt_inc;

  // Fetch wins unless both are waiting and fetch had the previous grant.
  assign sel_fetch = if_req && (!d_req || last_q == DATA);
  assign sel_addr  = sel_fetch ? if_addr : d_addr;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  mem_lane_align u_align (
    .is_fetch_i   (sel_fetch),
    .we_i         (d_we),
    .func_i       (d_func),
    .addr_lo_i    (sel_addr[1:0]),
    .wdata_i      (d_wdata),
    .wdata_o      (al_wdata),
    .wstrb_o      (al_wstrb),
    .err_o        (al_err),
    .ld_func_i    (func_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .rdata_i      (mem_rdata),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    func_d  = func_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_d   = sel_fetch ? FETCH : DATA;
          last_d  = gnt_d;
          we_d    = !sel_fetch && d_we;
          // A fetch is a plain word read, so the load formatter passes it through.
          func_d  = sel_fetch ? F_W : d_func;
          addr_d  = sel_addr;
          wdata_d = al_wdata;
          wstrb_d = al_wstrb;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = al_err;
          state_d = al_err ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_inc;
        if (mem_ack) begin
          rdata_d = we_q ? '0 : ld_data;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_inc == TIMEOUT_C) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= DATA;
      gnt_q   <= FETCH;
      we_q    <= 1'b0;
      func_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      func_q  <= func_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign mem_wstrb = mem_req ? wstrb_q : '0;

  assign if_ack   = (state_q == DONE) && (gnt_q == FETCH);
  assign d_ack    = (state_q == DONE) && (gnt_q == DATA);
  assign if_rdata = if_ack ? rdata_q : '0;
  assign d_rdata  = d_ack ? rdata_q : '0;
  assign if_err   = if_ack & err_q;
  assign d_err    = d_ack & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for the listed scenarios.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_func = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_func(d_func), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Memory responder: acks once mem_req has been high for lat+1 cycles.
  logic [31:0] mem_word = '0;
  int          lat = 0;
  int          hi_cnt = 0;
  always @(negedge clk) begin
    mem_rdata = mem_word;
    if (mem_req) begin
      mem_ack = (hi_cnt == lat);
      hi_cnt++;
    end else begin
      mem_ack = 1'b0;
      hi_cnt = 0;
    end
  end

  typedef struct packed {
    logic        fetch;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  // Reference behaviour: access size in bytes, legality, lane placement by arithmetic.
  function automatic exp_t predict(input logic fetch, input logic we, input logic [2:0] f,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] word);
    exp_t e;
    int size, a;
    bit sgn, legal;
    logic [31:0] v, mask;
    e = '0;
    e.fetch = fetch;
    e.we = !fetch && we;
    e.addr = addr & 32'hFFFF_FFFC;
    a = int'(addr[1:0]);
    size = 4; sgn = 1'b0; legal = 1'b1;
    if (!fetch) begin
      case (f)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: begin size = 1; legal = !we; end
        3'd5: begin size = 2; legal = !we; end
        default: legal = 1'b0;
      endcase
    end
    if (!legal || (a % size) != 0) begin
      e.err = 1'b1;
      return e;
    end
    if (e.we) begin
      e.wstrb = 4'((1 << size) - 1) << a;
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (word >> (8 * a)) & mask;
      if (sgn && size < 4 && v[8*size-1]) v = v | ~mask;
      e.rdata = v;
    end
    return e;
  endfunction

  // Per-cycle compare against the model.
  exp_t        m_exp;
  bit          m_busy = 1'b0;
  bit          m_last_data = 1'b1;
  bit          m_tout = 1'b0;
  bit          rst_prev = 1'b0;
  int          m_t = 0;
  int          m_end = 0;
  bit          grant_q[$];
  logic [31:0] obs_addr = '0;
  logic [31:0] obs_wdata = '0;
  logic [3:0]  obs_wstrb = '0;
  logic        obs_we = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (rst_prev) begin
        chk("rst_ctl", {22'b0, mem_req, mem_we, mem_wstrb, if_ack, d_ack, if_err, d_err}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
      end
      m_busy = 1'b0;
      m_last_data = 1'b1;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      if (!m_busy) begin
        chk("idle_ctl", {22'b0, mem_req, mem_we, mem_wstrb, if_ack, d_ack, if_err, d_err}, 32'h0);
        chk("idle_addr", mem_addr, 32'h0);
        chk("idle_wdata", mem_wdata, 32'h0);
        chk("idle_rdata", if_rdata | d_rdata, 32'h0);
        if (if_req || d_req) begin
          bit pick_fetch;
          pick_fetch = if_req && (!d_req || m_last_data);
          m_last_data = !pick_fetch;
          grant_q.push_back(pick_fetch);
          if (pick_fetch) m_exp = predict(1'b1, 1'b0, 3'd2, if_addr, 32'h0, mem_word);
          else            m_exp = predict(1'b0, d_we, d_func, d_addr, d_wdata, mem_word);
          m_tout = !m_exp.err && (lat + 1 > TIMEOUT);
          m_end = m_exp.err ? 0 : ((lat + 1 <= TIMEOUT) ? lat + 1 : TIMEOUT);
          m_t = 0;
          m_busy = 1'b1;
        end
      end else begin
        m_t++;
        if (m_t <= m_end) begin
          chk("acc_ctl", {28'b0, mem_req, mem_we, if_ack, d_ack}, {28'b0, 1'b1, m_exp.we, 2'b00});
          chk("acc_addr", mem_addr, m_exp.addr);
          chk("acc_wstrb", {28'b0, mem_wstrb}, {28'b0, m_exp.wstrb});
          if (m_exp.we) chk("acc_wdata", mem_wdata, m_exp.wdata);
          obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb; obs_we = mem_we;
        end else begin
          logic        e_err;
          logic [31:0] e_rd;
          e_err = m_exp.err | m_tout;
          e_rd = e_err ? 32'h0 : m_exp.rdata;
          chk("done_ctl", {27'b0, mem_req, if_ack, d_ack, if_err, d_err},
              {27'b0, 1'b0, m_exp.fetch, !m_exp.fetch, m_exp.fetch & e_err, !m_exp.fetch & e_err});
          chk("done_rdata", m_exp.fetch ? if_rdata : d_rdata, e_rd);
          m_busy = 1'b0;
        end
      end
    end
  end

  // One transaction from an idle cycle; cyc = cycle of the ack relative to the request.
  task automatic txn(input bit fetch, input bit we, input logic [2:0] f, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] word, input int l,
                     output logic [31:0] rd, output logic e, output int cyc);
    bit got;
    mem_word = word;
    lat = l;
    if (fetch) begin
      if_addr = addr; if_req = 1'b1;
    end else begin
      d_we = we; d_func = f; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    end
    cyc = 0; rd = '0; e = 1'b1; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk); #1;
      cyc++;
      got = fetch ? if_ack : d_ack;
    end
    chk("ack_seen", {31'b0, got}, 32'h1);
    if (got) begin
      rd = fetch ? if_rdata : d_rdata;
      e = fetch ? if_err : d_err;
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    $display("txn fetch=%0d we=%0d f=%0d addr=0x%08h -> rdata=0x%08h err=%0d ack_cycle=%0d",
             fetch, we, f, addr, rd, e, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          cyc;
    bit          ord[8];
    int          n_ack;
    exp_t        pm;

    pm = predict(1'b0, 1'b0, F_B, 32'h201, 32'h0, 32'h0000_80FF);
    chk("model_lb", pm.rdata, 32'hFFFF_FF80);
    pm = predict(1'b0, 1'b1, F_H, 32'h202, 32'h1234, 32'h0);
    chk("model_sh_strb", {28'b0, pm.wstrb}, 32'hC);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Round robin: both requesters held busy for 8 grants.
    mem_word = 32'h1234_5678; lat = 0;
    if_addr = 32'h100; d_we = 1'b0; d_func = F_W; d_addr = 32'h300;
    if_req = 1'b1; d_req = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 80 && n_ack < 8; c++) begin
      @(posedge clk); #1;
      if (if_ack) begin ord[n_ack] = 1'b1; n_ack++; end
      else if (d_ack) begin ord[n_ack] = 1'b0; n_ack++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    chk("rr_count", n_ack, 8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", {31'b0, ord[i]}, {31'b0, (i % 2) == 0});
      chk("rr_model", {31'b0, grant_q[i]}, {31'b0, (i % 2) == 0});
      $display("rr grant %0d: %s", i, ord[i] ? "fetch" : "data");
    end

    txn(1, 0, F_W, 32'h100, 0, 32'h0050_0093, 0, rd, e, cyc);
    chk("fetch_rdata", rd, 32'h0050_0093); chk("fetch_err", {31'b0, e}, 0);
    chk("fetch_cyc", cyc, 2); chk("fetch_addr", obs_addr, 32'h100); chk("fetch_we", {31'b0, obs_we}, 0);

    txn(0, 1, F_B, 32'h203, 32'hAB, 0, 0, rd, e, cyc);
    chk("sb_addr", obs_addr, 32'h200); chk("sb_wstrb", {28'b0, obs_wstrb}, 32'h8);
    chk("sb_wdata", obs_wdata, 32'hABAB_ABAB); chk("sb_err", {31'b0, e}, 0);

    txn(0, 1, F_H, 32'h202, 32'h1234, 0, 1, rd, e, cyc);
    chk("sh_wstrb", {28'b0, obs_wstrb}, 32'hC); chk("sh_wdata", obs_wdata, 32'h1234_1234);

    txn(0, 1, F_W, 32'h204, 32'hDEAD_BEEF, 0, 0, rd, e, cyc);
    chk("sw_wstrb", {28'b0, obs_wstrb}, 32'hF); chk("sw_wdata", obs_wdata, 32'hDEAD_BEEF);

    txn(0, 0, F_B, 32'h201, 0, 32'h0000_80FF, 2, rd, e, cyc);
    chk("lb_rdata", rd, 32'hFFFF_FF80); chk("lb_cyc", cyc, 4);
    txn(0, 0, F_BU, 32'h201, 0, 32'h0000_80FF, 0, rd, e, cyc);
    chk("lbu_rdata", rd, 32'h0000_0080);
    txn(0, 0, F_H, 32'h202, 0, 32'h8001_0000, 0, rd, e, cyc);
    chk("lh_rdata", rd, 32'hFFFF_8001);
    txn(0, 0, F_HU, 32'h202, 0, 32'h8001_0000, 0, rd, e, cyc);
    chk("lhu_rdata", rd, 32'h0000_8001);

    txn(0, 0, F_W, 32'h102, 0, 32'h5555_5555, 0, rd, e, cyc);
    chk("lw_mis_err", {31'b0, e}, 1); chk("lw_mis_cyc", cyc, 1); chk("lw_mis_rdata", rd, 0);
    txn(0, 0, 3'b011, 32'h100, 0, 32'h5555_5555, 0, rd, e, cyc);
    chk("ld_f3_err", {31'b0, e}, 1); chk("ld_f3_cyc", cyc, 1);
    txn(0, 1, F_BU, 32'h100, 32'h1, 0, 0, rd, e, cyc);
    chk("st_f3_err", {31'b0, e}, 1);
    txn(0, 0, F_H, 32'h101, 0, 0, 0, rd, e, cyc);
    chk("lh_mis_err", {31'b0, e}, 1);
    txn(1, 0, F_W, 32'h102, 0, 0, 0, rd, e, cyc);
    chk("fetch_mis_err", {31'b0, e}, 1); chk("fetch_mis_cyc", cyc, 1);

    txn(0, 0, F_W, 32'h300, 0, 32'hCAFE_F00D, TIMEOUT - 1, rd, e, cyc);
    chk("ack_at_limit_err", {31'b0, e}, 0); chk("ack_at_limit_rdata", rd, 32'hCAFE_F00D);
    chk("ack_at_limit_cyc", cyc, TIMEOUT + 1);
    txn(0, 0, F_W, 32'h300, 0, 32'hCAFE_F00D, 99, rd, e, cyc);
    chk("tout_err", {31'b0, e}, 1); chk("tout_rdata", rd, 0); chk("tout_cyc", cyc, TIMEOUT + 1);

    // Reset in the middle of an ACCESS.
    mem_word = 32'h0; lat = 99;
    d_we = 1'b0; d_func = F_W; d_addr = 32'h300; d_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_req", {31'b0, mem_req}, 1);
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_req", {31'b0, mem_req}, 0);
    chk("post_rst_ack", {30'b0, if_ack, d_ack}, 0);
    $display("reset mid-access: mem_req=%0d if_ack=%0d d_ack=%0d", mem_req, if_ack, d_ack);
    @(posedge clk); #1;
    txn(1, 0, F_W, 32'h104, 0, 32'h0000_0013, 1, rd, e, cyc);
    chk("post_rst_fetch", rd, 32'h0000_0013); chk("post_rst_cyc", cyc, 3);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
